// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte-stream requesters, the shared-UART arbiter and
// the transmitter holding-register write port.
interface uart_tx_arbiter_if #(
    parameter int NREQ = 4
);
    logic                enable;
    logic [NREQ-1:0]     req;
    logic [8*NREQ-1:0]   req_data;
    logic [NREQ-1:0]     req_last;
    logic [NREQ-1:0]     ack;
    logic [NREQ-1:0]     grant;
    logic [7:0]          tx_hold_reg;
    logic                tx_wr;
    logic                txrdy;
    logic                busy;

    // master: requesters plus the transmitter's ready flag
    modport master (
        output enable, req, req_data, req_last, txrdy,
        input  ack, grant, tx_hold_reg, tx_wr, busy
    );

    modport slave (
        input  enable, req, req_data, req_last, txrdy,
        output ack, grant, tx_hold_reg, tx_wr, busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte streams; the
// grant is locked per packet/burst and every byte write is paced against txrdy.
module uart_tx_arbiter #(
    parameter int NREQ      = 4,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              reset,
    uart_tx_arbiter_if.slave  bus
);
    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {IDLE, SEND, HOLDOFF, RELEASE} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   owner_q, owner_d;
    logic [CW-1:0]   burst_q, burst_d;
    logic            last_q, last_d;
    logic [NREQ-1:0] grant_q, grant_d;
    logic [NREQ-1:0] ack_q, ack_d;
    logic [7:0]      hold_q, hold_d;
    logic            tx_wr_q, tx_wr_d;
    logic            busy_q, busy_d;

    logic [PW-1:0]   pick_idx;
    logic            pick_found;
    logic [7:0]      req_byte [NREQ];

    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
            assign req_byte[gi] = bus.req_data[8*gi +: 8];
        end
    endgenerate

    // First requesting index at or after the pointer, wrapping modulo NREQ.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            int            idx;
            logic [PW-1:0] idx_v;
            idx = int'(ptr_q) + k;
            if (idx >= NREQ) idx = idx - NREQ;
            idx_v = PW'(idx);
            if (!pick_found && bus.req[idx_v]) begin
                pick_found = 1'b1;
                pick_idx   = idx_v;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        burst_d = burst_q;
        last_d  = last_q;
        grant_d = grant_q;
        ack_d   = '0;
        hold_d  = hold_q;
        tx_wr_d = 1'b0;
        busy_d  = busy_q;

        case (state_q)
            IDLE: begin
                if (bus.enable && pick_found) begin
                    owner_d           = pick_idx;
                    grant_d           = '0;
                    grant_d[pick_idx] = 1'b1;
                    busy_d            = 1'b1;
                    burst_d           = '0;
                    state_d           = SEND;
                end
            end
            SEND: begin
                if (!bus.req[owner_q]) begin
                    state_d = RELEASE;
                end else if (bus.txrdy) begin
                    hold_d         = req_byte[owner_q];
                    tx_wr_d        = 1'b1;
                    ack_d[owner_q] = 1'b1;
                    last_d         = bus.req_last[owner_q];
                    burst_d        = burst_q + CW'(1);
                    state_d        = HOLDOFF;
                end
            end
            // txrdy is still stale here: the transmitter drops it a cycle after tx_wr.
            HOLDOFF: begin
                if (last_q || (burst_q == CW'(MAX_BURST)) || !bus.enable) begin
                    state_d = RELEASE;
                end else begin
                    state_d = SEND;
                end
            end
            RELEASE: begin
                grant_d = '0;
                busy_d  = 1'b0;
                ptr_d   = (owner_q == PW'(NREQ - 1)) ? '0 : owner_q + PW'(1);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
            last_q  <= 1'b0;
            grant_q <= '0;
            ack_q   <= '0;
            hold_q  <= 8'h00;
            tx_wr_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
            last_q  <= last_d;
            grant_q <= grant_d;
            ack_q   <= ack_d;
            hold_q  <= hold_d;
            tx_wr_q <= tx_wr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.ack         = ack_q;
    assign bus.grant       = grant_q;
    assign bus.tx_hold_reg = hold_q;
    assign bus.tx_wr       = tx_wr_q;
    assign bus.busy        = busy_q;

endmodule
